program_fetch_controller: RTL and testbench

Instruction-fetch sequencer in front of the combinational program ROM of the single-cycle MIPS core. It owns the program counter, drives the ROM address, applies stall and redirect (branch/jump) requests from the core, and time-shares the ROM read port with a debug/monitor read requester. It also halts fetch on any out-of-range or misaligned PC.

---
 rtl/program_fetch_controller_pkg.sv | 15 +
 rtl/program_fetch_controller_if.sv | 56 +++++
 rtl/fetch_addr_check.sv | 24 ++
 rtl/program_fetch_controller.sv | 121 ++++++++++++
 tb/tb_program_fetch_controller.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/program_fetch_controller_pkg.sv
// Shared definitions for the program fetch controller: state encoding and
// program-memory constants.
package program_fetch_controller_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StDbg  = 2'd2,
    StHalt = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DefaultResetPc = 32'h0040_0000;
  localparam int unsigned WordBytes      = 4;

endpackage

// File: rtl/program_fetch_controller_if.sv
// Core/ROM/debug signal bundle for the program fetch controller.
// The slave modport is the controller; master is the core/ROM/debug side.
interface program_fetch_controller_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  Stall;
  logic                  Redirect;
  logic [DATA_WIDTH-1:0] RedirectTarget;
  logic [DATA_WIDTH-1:0] MemAddress;
  logic [DATA_WIDTH-1:0] MemInstruction;
  logic [DATA_WIDTH-1:0] PC;
  logic [DATA_WIDTH-1:0] PCPlus4;
  logic [DATA_WIDTH-1:0] Instruction;
  logic                  InstrValid;
  logic                  DbgReq;
  logic [DATA_WIDTH-1:0] DbgAddr;
  logic                  DbgAck;
  logic [DATA_WIDTH-1:0] DbgData;
  logic                  Fault;

  modport slave (
    input  Stall,
    input  Redirect,
    input  RedirectTarget,
    input  MemInstruction,
    input  DbgReq,
    input  DbgAddr,
    output MemAddress,
    output PC,
    output PCPlus4,
    output Instruction,
    output InstrValid,
    output DbgAck,
    output DbgData,
    output Fault
  );

  modport master (
    output Stall,
    output Redirect,
    output RedirectTarget,
    output MemInstruction,
    output DbgReq,
    output DbgAddr,
    input  MemAddress,
    input  PC,
    input  PCPlus4,
    input  Instruction,
    input  InstrValid,
    input  DbgAck,
    input  DbgData,
    input  Fault
  );

endinterface

// File: rtl/fetch_addr_check.sv
// Flags a fetch address that is misaligned or outside the program memory
// window [RESET_PC, RESET_PC + 4*MEMORY_DEPTH).
module fetch_addr_check
  import program_fetch_controller_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(DefaultResetPc),
  parameter int unsigned           MEMORY_DEPTH = 'h200
) (
  input  logic [DATA_WIDTH-1:0] addr,
  output logic                  bad
);

  // One extra bit so a window reaching the top of the address space still compares correctly.
  localparam logic [DATA_WIDTH:0] Span = (DATA_WIDTH+1)'(MEMORY_DEPTH * WordBytes);

  logic [DATA_WIDTH-1:0] offset;

  always_comb begin
    offset = addr - RESET_PC;
    bad    = (addr[1:0] != 2'b00) || (addr < RESET_PC) || ({1'b0, offset} >= Span);
  end

endmodule

// File: rtl/program_fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, applies stall/redirect, shares the
// ROM port with debug reads and halts fetch on a bad PC.
module program_fetch_controller
  import program_fetch_controller_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(DefaultResetPc),
  parameter int unsigned           MEMORY_DEPTH = 'h200
) (
  input logic                      clk,
  input logic                      reset,
  program_fetch_controller_if.slave bus
);

  fetch_state_e          state_q, state_d;
  logic                  ret_halt_q, ret_halt_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] dbg_data_q, dbg_data_d;
  logic                  dbg_ack_q, dbg_ack_d;
  logic                  fault_q, fault_d;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  next_bad;
  logic                  pc_bad;
  logic                  instr_valid;
  logic                  grant;

  assign pc_plus4 = pc_q + DATA_WIDTH'(WordBytes);
  assign next_pc  = bus.Redirect ? bus.RedirectTarget : pc_plus4;

  fetch_addr_check #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESET_PC    (RESET_PC),
    .MEMORY_DEPTH(MEMORY_DEPTH)
  ) u_next_check (
    .addr(next_pc),
    .bad (next_bad)
  );

  // Guards the presented word; the PC register never holds a bad value in RUN.
  fetch_addr_check #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESET_PC    (RESET_PC),
    .MEMORY_DEPTH(MEMORY_DEPTH)
  ) u_pc_check (
    .addr(pc_q),
    .bad (pc_bad)
  );

  assign grant = ((state_q == StRun) || (state_q == StHalt)) && bus.DbgReq && !dbg_ack_q;

  always_comb begin
    state_d    = state_q;
    ret_halt_d = ret_halt_q;
    pc_d       = pc_q;
    dbg_ack_d  = 1'b0;
    dbg_data_d = dbg_data_q;
    fault_d    = fault_q;

    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (bus.Redirect || !bus.Stall) begin
          if (next_bad) begin
            state_d = StHalt;
            fault_d = 1'b1;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      StDbg: begin
        state_d    = ret_halt_q ? StHalt : StRun;
        dbg_ack_d  = 1'b1;
        dbg_data_d = bus.MemInstruction;
      end
      StHalt: state_d = StHalt;
      default: state_d = StHalt;
    endcase

    // The return bit captures where this edge would have gone, so RUN->HALT
    // coinciding with a grant returns to HALT.
    if (grant) begin
      ret_halt_d = (state_d == StHalt);
      state_d    = StDbg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StBoot;
      ret_halt_q <= 1'b0;
      pc_q       <= RESET_PC;
      dbg_ack_q  <= 1'b0;
      dbg_data_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_halt_q <= ret_halt_d;
      pc_q       <= pc_d;
      dbg_ack_q  <= dbg_ack_d;
      dbg_data_q <= dbg_data_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    instr_valid     = (state_q == StRun) && !pc_bad;
    bus.MemAddress  = (state_q == StDbg) ? bus.DbgAddr : pc_q;
    bus.Instruction = instr_valid ? bus.MemInstruction : '0;
  end

  assign bus.InstrValid = instr_valid;
  assign bus.PC         = pc_q;
  assign bus.PCPlus4    = pc_plus4;
  assign bus.DbgAck     = dbg_ack_q;
  assign bus.DbgData    = dbg_data_q;
  assign bus.Fault      = fault_q;

endmodule

// File: tb/tb_program_fetch_controller.sv
// Scoreboard bench: the driver queues expected fetches and debug replies, and
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_program_fetch_controller;

  localparam logic [31:0] Base = 32'h0040_0000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] fetch_q[$];
  logic [31:0] dbg_q[$];

  program_fetch_controller_if #(.DATA_WIDTH(32)) bus ();

  program_fetch_controller #(
    .DATA_WIDTH  (32),
    .RESET_PC    (32'h0040_0000),
    .MEMORY_DEPTH('h200)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - Base;
    if (a >= Base && off < 32'h800) return {16'hC0DE, off[17:2]};
    return 32'hBAD0_0BAD;
  endfunction

  assign bus.MemInstruction = rom_word(bus.MemAddress);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: consumes expectations only when the DUT presents a fetch or an ack.
  always @(negedge clk) begin
    if (bus.InstrValid) begin
      if (fetch_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch: got pc %h expected no fetch", bus.PC);
      end else begin
        logic [31:0] e;
        e = fetch_q.pop_front();
        chk("fetch_pc", bus.PC, e);
        chk("fetch_instr", bus.Instruction, rom_word(e));
        chk("pcplus4", bus.PCPlus4, e + 32'd4);
      end
    end else begin
      chk("instr_zero", bus.Instruction, 32'h0);
    end
    if (bus.DbgAck) begin
      if (dbg_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got data %h expected no ack", bus.DbgData);
      end else begin
        logic [31:0] d;
        d = dbg_q.pop_front();
        chk("dbg_data", bus.DbgData, d);
      end
    end
  end

  // One cycle of stimulus plus the expectations for that same cycle.
  task automatic tick(input logic st, input logic rd, input logic [31:0] tgt,
                      input logic dreq, input logic [31:0] daddr,
                      input bit expv, input logic [31:0] epc,
                      input bit expack, input logic [31:0] edata, input logic efault);
    @(posedge clk);
    #1;
    bus.Stall          = st;
    bus.Redirect       = rd;
    bus.RedirectTarget = tgt;
    bus.DbgReq         = dreq;
    bus.DbgAddr        = daddr;
    if (expv) fetch_q.push_back(epc);
    if (expack) dbg_q.push_back(edata);
    #1;
    chk("fault", {31'b0, bus.Fault}, {31'b0, efault});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset      = 1'b1;
    bus.Stall  = 1'b0;
    bus.Redirect = 1'b0;
    bus.DbgReq = 1'b0;
    #1;
    chk("rst_pc", bus.PC, Base);
    chk("rst_memaddr", bus.MemAddress, Base);
    chk("rst_valid", {31'b0, bus.InstrValid}, 32'h0);
    chk("rst_instr", bus.Instruction, 32'h0);
    chk("rst_ack", {31'b0, bus.DbgAck}, 32'h0);
    chk("rst_dbgdata", bus.DbgData, 32'h0);
    chk("rst_fault", {31'b0, bus.Fault}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;  // this cycle is BOOT
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    reset              = 1'b1;
    bus.Stall          = 1'b0;
    bus.Redirect       = 1'b0;
    bus.RedirectTarget = '0;
    bus.DbgReq         = 1'b0;
    bus.DbgAddr        = '0;

    do_reset();
    // Sequential fetch after reset release
    tick(0, 0, 0, 0, 0, 1, 32'h0040_0000, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1, 32'h0040_0004, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1, 32'h0040_0008, 0, 0, 0);
    // Stall x3, redirect wins in the second stalled cycle
    tick(1, 0, 0,             0, 0, 1, 32'h0040_000C, 0, 0, 0);
    tick(1, 1, 32'h0040_0040, 0, 0, 1, 32'h0040_000C, 0, 0, 0);
    tick(1, 0, 0,             0, 0, 1, 32'h0040_0040, 0, 0, 0);
    tick(0, 0, 0,             0, 0, 1, 32'h0040_0040, 0, 0, 0);
    // Single debug read of rom[3]
    tick(0, 0, 0, 1, 32'h0040_000C, 1, 32'h0040_0044, 0, 0, 0);
    tick(0, 0, 0, 1, 32'h0040_000C, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 32'h0040_000C, 1, 32'h0040_0048, 1, 32'hC0DE_0003, 0);
    tick(0, 0, 0, 0, 0, 1, 32'h0040_004C, 0, 0, 0);
    // DbgReq held: grants alternate with fetch cycles
    tick(0, 0, 0, 1, 32'h0040_0010, 1, 32'h0040_0050, 0, 0, 0);
    tick(0, 0, 0, 1, 32'h0040_0010, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 32'h0040_0010, 1, 32'h0040_0054, 1, 32'hC0DE_0004, 0);
    tick(0, 0, 0, 1, 32'h0040_0010, 1, 32'h0040_0058, 0, 0, 0);
    tick(0, 0, 0, 1, 32'h0040_0010, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 32'h0040_0010, 1, 32'h0040_005C, 1, 32'hC0DE_0004, 0);
    tick(0, 0, 0, 0, 0, 1, 32'h0040_0060, 0, 0, 0);
    // Misaligned redirect halts; redirect ignored; debug still served
    tick(0, 1, 32'h0040_0002, 0, 0, 1, 32'h0040_0064, 0, 0, 0);
    tick(0, 1, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 1, 32'h0040_0020, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 1, 32'h0040_0020, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 0, 1, 32'hC0DE_0008, 1);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Last word is legal; redirect one past the end halts
    do_reset();
    tick(0, 1, 32'h0040_07FC, 0, 0, 1, 32'h0040_0000, 0, 0, 0);
    tick(0, 1, 32'h0040_0800, 0, 0, 1, 32'h0040_07FC, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset during DBG aborts the read
    do_reset();
    tick(0, 0, 0, 1, 32'h0040_000C, 1, 32'h0040_0000, 0, 0, 0);
    do_reset();
    chk("abort_ack", {31'b0, bus.DbgAck}, 32'h0);
    // Sequential fetch running off the end halts
    tick(0, 1, 32'h0040_07F8, 0, 0, 1, 32'h0040_0000, 0, 0, 0);
    tick(0, 0, 0,             0, 0, 1, 32'h0040_07F8, 0, 0, 0);
    tick(0, 0, 0,             0, 0, 1, 32'h0040_07FC, 0, 0, 0);
    tick(0, 0, 0,             0, 0, 0, 0, 0, 0, 1);

    @(negedge clk);
    #1;
    chk("fetch_q_empty", fetch_q.size(), 32'd0);
    chk("dbg_q_empty", dbg_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
